// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - command codes, sequencer states and quarter-phase pin table for i2c_master
package i2c_pkg;

    localparam logic [2:0] CMD_NOP       = 3'd0;
    localparam logic [2:0] CMD_START     = 3'd1;
    localparam logic [2:0] CMD_STOP      = 3'd2;
    localparam logic [2:0] CMD_WRITE     = 3'd3;
    localparam logic [2:0] CMD_READ_ACK  = 3'd4;
    localparam logic [2:0] CMD_READ_NACK = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_STOP, ST_WRITE, ST_READ, ST_ACK, ST_DONE
    } state_t;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    // Returns {scl, sda} drive for a quarter; data_bit is the SDA level of a data/ACK bit.
    function automatic logic [1:0] quarter_pins(state_t st, logic [1:0] q, logic data_bit);
        logic [1:0] p;
        p = 2'b11;
        case (st)
            ST_START: p = (q == Q0 || q == Q1) ? 2'b11 : (q == Q2) ? 2'b10 : 2'b00;
            ST_STOP:  p = (q == Q0) ? 2'b00 : (q == Q1) ? 2'b10 : 2'b11;
            ST_WRITE, ST_READ, ST_ACK: p = {(q == Q1 || q == Q2), data_bit};
            default:  p = 2'b11;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// rtl/i2c_quarter_tick.sv - quarter-bit down-counter producing end-of-quarter ticks with hold
module i2c_quarter_tick #(
    parameter int CLK_DIV   = 125,
    parameter int DIV_WIDTH = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    input  logic hold,
    output logic tick,
    output logic pre_tick
);

    localparam logic [DIV_WIDTH-1:0] RELOAD = DIV_WIDTH'(CLK_DIV - 1);

    logic [DIV_WIDTH-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= RELOAD;
        end else if (restart || (cnt == '0 && !hold)) begin
            cnt <= RELOAD;
        end else if (!hold) begin
            cnt <= cnt - DIV_WIDTH'(1);
        end
    end

    // pre_tick flags that the next cycle is the final cycle of the current quarter
    assign tick     = (cnt == '0) && !hold;
    assign pre_tick = (cnt == DIV_WIDTH'(1)) && !hold;

endmodule

// File: rtl/i2c_master.sv
// rtl/i2c_master.sv - byte-level I2C master sequencer; I2C_CLOCK_STRETCH_EN enables SCL stretching
module i2c_master #(
    parameter int CLK_DIV   = 125,
    parameter int DIV_WIDTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd,
    input  logic [7:0] wr_data,
    output logic [7:0] rd_data,
    output logic       rd_ack,
    output logic       done,
    input  logic       ext_scl_i,
    output logic       ext_scl_o,
    input  logic       ext_sda_i,
    output logic       ext_sda_o
);
    import i2c_pkg::*;

    state_t     state, cmd_st;
    logic [1:0] quarter;
    logic [2:0] bit_idx;
    logic [7:0] shreg;
    logic       is_read, ack_level, sample_pend;
    logic       accept, active, last_bit, hold, tick, pre_tick, finish, data_bit, next_bit;

    assign accept   = cmd_valid && cmd_ready;
    assign active   = state inside {ST_START, ST_STOP, ST_WRITE, ST_READ, ST_ACK};
    assign last_bit = state inside {ST_START, ST_STOP, ST_ACK};

`ifdef I2C_CLOCK_STRETCH_EN
    assign hold = active && (quarter == Q1 || quarter == Q2) && !ext_scl_i;
`else
    logic unused_scl;
    assign unused_scl = ext_scl_i;
    assign hold       = 1'b0;
`endif

    i2c_quarter_tick #(.CLK_DIV(CLK_DIV), .DIV_WIDTH(DIV_WIDTH)) u_tick (
        .clk      (clk),
        .reset    (reset),
        .restart  (accept),
        .hold     (hold),
        .tick     (tick),
        .pre_tick (pre_tick)
    );

    // done must coincide with the final cycle of q3, so it is raised one cycle early
    assign finish = last_bit && ((CLK_DIV == 1) ? (quarter == Q2 && tick) : (quarter == Q3 && pre_tick));

    always_comb begin
        cmd_st = ST_DONE;
        case (cmd)
            CMD_NOP:                     cmd_st = ST_DONE;
            CMD_START:                   cmd_st = ST_START;
            CMD_STOP:                    cmd_st = ST_STOP;
            CMD_WRITE:                   cmd_st = ST_WRITE;
            CMD_READ_ACK, CMD_READ_NACK: cmd_st = ST_READ;
            default:                     cmd_st = ST_DONE;
        endcase
    end

    always_comb begin
        data_bit = 1'b1;
        if (state == ST_WRITE)
            data_bit = shreg[7];
        else if (state == ST_ACK && is_read)
            data_bit = ack_level;
        next_bit = 1'b1;
        if (bit_idx == 3'd7)
            next_bit = is_read ? ack_level : 1'b1;
        else if (state == ST_WRITE)
            next_bit = shreg[6];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            quarter     <= Q0;
            bit_idx     <= '0;
            shreg       <= '0;
            is_read     <= 1'b0;
            ack_level   <= 1'b1;
            sample_pend <= 1'b0;
            cmd_ready   <= 1'b1;
            done        <= 1'b0;
            rd_data     <= '0;
            rd_ack      <= 1'b0;
            ext_scl_o   <= 1'b1;
            ext_sda_o   <= 1'b1;
        end else begin
            done        <= 1'b0;
            sample_pend <= active && tick && quarter == Q1;
            if (sample_pend) begin
                if (state == ST_READ)
                    shreg <= {shreg[6:0], ext_sda_i};
                if (state == ST_ACK && !is_read)
                    rd_ack <= ext_sda_i;
            end
            case (state)
                ST_IDLE: if (accept) begin
                    cmd_ready <= 1'b0;
                    quarter   <= Q0;
                    bit_idx   <= '0;
                    shreg     <= wr_data;
                    is_read   <= (cmd == CMD_READ_ACK) || (cmd == CMD_READ_NACK);
                    ack_level <= (cmd != CMD_READ_ACK);
                    state     <= cmd_st;
                    if (cmd_st == ST_DONE)
                        done <= 1'b1;
                    else
                        {ext_scl_o, ext_sda_o} <= quarter_pins(cmd_st, Q0, (cmd_st != ST_WRITE) || wr_data[7]);
                end
                ST_DONE: begin
                    state     <= ST_IDLE;
                    cmd_ready <= 1'b1;
                end
                default: if (finish) begin
                    state <= ST_DONE;
                    done  <= 1'b1;
                    {ext_scl_o, ext_sda_o} <= quarter_pins(state, Q3, data_bit);
                    if (state == ST_ACK && is_read)
                        rd_data <= shreg;
                end else if (tick) begin
                    if (quarter != Q3) begin
                        quarter <= quarter + 2'd1;
                        {ext_scl_o, ext_sda_o} <= quarter_pins(state, quarter + 2'd1, data_bit);
                    end else begin
                        quarter <= Q0;
                        bit_idx <= bit_idx + 3'd1;
                        if (state == ST_WRITE)
                            shreg <= {shreg[6:0], 1'b0};
                        if (bit_idx == 3'd7)
                            state <= ST_ACK;
                        {ext_scl_o, ext_sda_o} <= {1'b0, next_bit};
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master.sv
// tb/tb_i2c_master.sv - randomized self-checking bench for i2c_master with an open-drain bus and slave model
module tb_i2c_master;

    localparam int D = 4;
`ifdef I2C_CLOCK_STRETCH_EN
    localparam int STRETCH_ADD = 20;
`else
    localparam int STRETCH_ADD = 0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd;
    logic [7:0] wr_data;
    logic [7:0] rd_data;
    logic       rd_ack;
    logic       done;
    logic       ext_scl_o, ext_sda_o;
    logic       slave_scl_low, slave_sda;
    logic       scl_bus, sda_bus;

    assign scl_bus = ext_scl_o & ~slave_scl_low;
    assign sda_bus = ext_sda_o & slave_sda;

    i2c_master #(.CLK_DIV(D), .DIV_WIDTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd       (cmd),
        .wr_data   (wr_data),
        .rd_data   (rd_data),
        .rd_ack    (rd_ack),
        .done      (done),
        .ext_scl_i (scl_bus),
        .ext_scl_o (ext_scl_o),
        .ext_sda_i (sda_bus),
        .ext_sda_o (ext_sda_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Observations of the last command, and the reference view of the result registers
    logic [8:0] bits_seen;
    int         n_rise, n_start, n_stop, n_toggle, latency, n_done;
    logic [7:0] m_rd_data;
    logic       m_rd_ack;

    task automatic run_cmd(input logic [2:0] code, input logic [7:0] data, input logic [8:0] sbits,
                           input bit stretch, input bit poke);
        int   idx, c, srem, nrise_o;
        logic pscl, psda, pscl_o, scl, sda;
        @(negedge clk);
        check_eq("ready_before", cmd_ready, 1);
        cmd_valid = 1'b1; cmd = code; wr_data = data;
        idx = 0; c = 0; srem = 0; nrise_o = 0; latency = -1; n_done = 0;
        n_rise = 0; n_start = 0; n_stop = 0; n_toggle = 0; bits_seen = '0;
        slave_sda = sbits[8];
        pscl = scl_bus; psda = sda_bus; pscl_o = ext_scl_o;
        while (c < 3000 && !(latency >= 0 && c >= latency + 4)) begin
            @(negedge clk);
            c++;
            if (c == 1) begin
                cmd_valid = 1'b0;
                check_eq("ready_drop", cmd_ready, 0);
            end
            if (poke) begin
                cmd_valid = (c >= 10 && c < 20);
                cmd = 3'd1;
            end
            if (done) begin
                n_done++;
                if (latency < 0) latency = c;
            end
            if (latency >= 0 && c == latency + 1)
                check_eq("ready_after", cmd_ready, 1);
            scl = scl_bus; sda = sda_bus;
            if (scl && !pscl) begin
                if (n_rise < 9) bits_seen[8 - n_rise] = sda;
                n_rise++;
            end
            if (scl && pscl && psda && !sda) n_start++;
            if (scl && pscl && !psda && sda) n_stop++;
            if (scl != pscl || sda != psda) n_toggle++;
            if (!scl && pscl) idx++;
            slave_sda = (idx <= 8) ? sbits[8 - idx] : 1'b1;
            if (srem > 0) begin
                srem--;
                if (srem == 0) slave_scl_low = 1'b0;
            end
            if (ext_scl_o && !pscl_o) begin
                nrise_o++;
                if (stretch && nrise_o == 4) begin
                    slave_scl_low = 1'b1;
                    srem = 20;
                end
            end
            pscl = scl; psda = sda; pscl_o = ext_scl_o;
        end
        cmd_valid = 1'b0;
        slave_sda = 1'b1;
        slave_scl_low = 1'b0;
        check_eq("done_count", n_done, 1);
    endtask

    task automatic apply(input logic [2:0] code, input logic [7:0] data, input logic [7:0] sdata,
                         input logic sack, input bit stretch, input bit poke);
        logic [8:0] sb;
        int         exp_lat;
        bit         is_wr, is_rd;
        is_wr = (code == 3'd3);
        is_rd = (code == 3'd4 || code == 3'd5);
        sb = is_wr ? {8'hFF, sack} : is_rd ? {sdata, 1'b1} : 9'h1FF;
        if (is_wr || is_rd)               exp_lat = 36 * D + (stretch ? STRETCH_ADD : 0);
        else if (code == 3'd1 || code == 3'd2) exp_lat = 4 * D;
        else                              exp_lat = 1;
        run_cmd(code, data, sb, stretch, poke);
        check_eq($sformatf("latency_c%0d", code), latency, exp_lat);
        if (code == 3'd1) check_eq("start_cond", n_start, 1);
        if (code == 3'd2) check_eq("stop_cond", n_stop, 1);
        if (exp_lat == 1) check_eq("nop_toggles", n_toggle, 0);
        if ((is_wr || is_rd) && (!stretch || STRETCH_ADD > 0)) begin
            check_eq("scl_rises", n_rise, 9);
            check_eq("sda_bits", bits_seen, is_wr ? {data, sack} : {sdata, code == 3'd5});
        end
        if (is_wr) m_rd_ack = sack;
        if (is_rd) m_rd_data = sdata;
        check_eq("rd_data", rd_data, m_rd_data);
        check_eq("rd_ack", rd_ack, m_rd_ack);
    endtask

    initial begin
        int   nr;
        logic pso;
        reset = 1'b1; cmd_valid = 1'b0; cmd = '0; wr_data = '0;
        slave_scl_low = 1'b0; slave_sda = 1'b1;
        m_rd_data = '0; m_rd_ack = 1'b0;
        #23;
        check_eq("rst_ready", cmd_ready, 1);
        check_eq("rst_done", done, 0);
        check_eq("rst_rd_data", rd_data, 0);
        check_eq("rst_rd_ack", rd_ack, 0);
        check_eq("rst_pins", {ext_scl_o, ext_sda_o}, 2'b11);
        @(negedge clk);
        reset = 1'b0;

        apply(3'd1, 8'h00, 8'h00, 1'b1, 0, 0);
        apply(3'd3, 8'hA5, 8'h00, 1'b0, 0, 0);
        apply(3'd5, 8'h00, 8'h3C, 1'b1, 0, 0);
        apply(3'd4, 8'h00, 8'($urandom_range(0, 255)), 1'b1, 0, 0);
        apply(3'd3, 8'($urandom_range(0, 255)), 8'h00, 1'b1, 1, 0);
        apply(3'd7, 8'h00, 8'h00, 1'b1, 0, 0);
        apply(3'd3, 8'($urandom_range(0, 255)), 8'h00, 1'b0, 0, 1);
        apply(3'd2, 8'h00, 8'h00, 1'b1, 0, 0);

        for (int r = 0; r < 3; r++) begin
            apply(3'd1, 8'h00, 8'h00, 1'b1, 0, 0);
            for (int k = 0; k < 4; k++) begin
                int       op;
                logic [2:0] code;
                op = $urandom_range(0, 4);
                case (op)
                    0:       code = 3'd3;
                    1:       code = 3'd4;
                    2:       code = 3'd5;
                    3:       code = 3'd1;
                    default: code = ($urandom_range(0, 2) == 0) ? 3'd0 : ($urandom_range(0, 1) == 0 ? 3'd6 : 3'd7);
                endcase
                apply(code, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 0, 0);
            end
            apply(3'd2, 8'h00, 8'h00, 1'b1, 0, 0);
        end

        // Reset in the middle of bit 5 of a WRITE
        apply(3'd1, 8'h00, 8'h00, 1'b1, 0, 0);
        @(negedge clk);
        cmd_valid = 1'b1; cmd = 3'd3; wr_data = 8'($urandom_range(0, 255));
        @(negedge clk);
        cmd_valid = 1'b0;
        nr = 0; pso = ext_scl_o;
        for (int i = 0; i < 1000 && nr < 6; i++) begin
            @(negedge clk);
            if (ext_scl_o && !pso) nr++;
            pso = ext_scl_o;
        end
        check_eq("reach_bit5", nr, 6);
        #2 reset = 1'b1;
        #1;
        check_eq("mid_rst_pins", {ext_scl_o, ext_sda_o}, 2'b11);
        check_eq("mid_rst_ready", cmd_ready, 1);
        check_eq("mid_rst_done", done, 0);
        @(negedge clk);
        reset = 1'b0;
        m_rd_data = '0; m_rd_ack = 1'b0;
        nr = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) nr++;
        end
        check_eq("no_done_after_rst", nr, 0);
        apply(3'd6, 8'h00, 8'h00, 1'b1, 0, 0);
        apply(3'd1, 8'h00, 8'h00, 1'b1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
